// File: rtl/fft_pkg.sv
// Shared defaults and state encoding for the FFT frame sequencer slice.
package fft_pkg;

    localparam int DEFAULT_BIT_WIDTH = 16;
    localparam int DEFAULT_N         = 9;
    localparam int DEFAULT_FFT_SIZE  = 2 ** DEFAULT_N;

    typedef enum logic [2:0] {
        FILL,
        IDLE,
        PREFETCH,
        LOAD,
        RUN
    } seq_state_t;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample buffer: one write and one registered read per cycle.
// A same-cycle read and write of one address returns the old contents.
module sample_ram
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter int N         = DEFAULT_N,
    parameter int DEPTH     = DEFAULT_FFT_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [N-1:0]         wr_addr,
    input  logic [BIT_WIDTH-1:0] wr_data,
    input  logic                 re,
    input  logic [N-1:0]         rd_addr,
    output logic [BIT_WIDTH-1:0] rd_data
);

    logic [BIT_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset; the array keeps its contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Circular sample buffer that replays the newest FFT_SIZE samples to the FFT
// every HOP new samples, then holds fft_start until the FFT reports done.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter int N         = DEFAULT_N,
    parameter int FFT_SIZE  = DEFAULT_FFT_SIZE,
    parameter int HOP       = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [BIT_WIDTH-1:0] sample_in,
    input  logic                 fft_done,
    output logic                 fft_load,
    output logic [N-1:0]         add_rd,
    output logic [BIT_WIDTH-1:0] din,
    output logic                 fft_start,
    output logic                 primed,
    output logic [15:0]          frame_count,
    output logic [7:0]           overrun_count
);

    localparam int HW = $clog2(2 * HOP + 1);
    localparam logic [N-1:0]  LAST_ADDR = N'(FFT_SIZE - 1);
    localparam logic [HW-1:0] HOP_V     = HW'(HOP);
    localparam logic [HW-1:0] HOP2_V    = HW'(2 * HOP);

    seq_state_t state, state_next;

    logic [N-1:0]  wr_ptr, wr_ptr_next, base;
    logic [HW-1:0] hop_cnt, hop_inc, hop_cnt_next;
    logic          overrun_hit;
    logic          ram_re;
    logic [N-1:0]  ram_rd_addr;

    assign wr_ptr_next = wr_ptr + N'(sample_valid);
    assign hop_inc     = hop_cnt + HW'(sample_valid);

    always_comb begin
        state_next   = state;
        hop_cnt_next = hop_inc;
        overrun_hit  = 1'b0;
        ram_re       = 1'b0;
        ram_rd_addr  = base + add_rd + N'(1);

        unique case (state)
            FILL: begin
                // Hop accounting starts once the first full frame is scheduled.
                hop_cnt_next = '0;
                if (sample_valid && wr_ptr == LAST_ADDR) begin
                    state_next = PREFETCH;
                end
            end
            IDLE: begin
                if (hop_inc >= HOP_V) begin
                    state_next = PREFETCH;
                end
            end
            PREFETCH: begin
                hop_cnt_next = HW'(sample_valid);
                ram_re       = 1'b1;
                ram_rd_addr  = wr_ptr_next;
                state_next   = LOAD;
            end
            LOAD: begin
                ram_re = (add_rd != LAST_ADDR);
                if (add_rd == LAST_ADDR) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (fft_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase

        // Keep at most one pending frame, anchored on the newest data.
        if ((state == LOAD || state == RUN) && hop_inc >= HOP2_V) begin
            overrun_hit  = 1'b1;
            hop_cnt_next = HOP_V;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= FILL;
            wr_ptr        <= '0;
            hop_cnt       <= '0;
            base          <= '0;
            add_rd        <= '0;
            fft_load      <= 1'b0;
            fft_start     <= 1'b0;
            primed        <= 1'b0;
            frame_count   <= '0;
            overrun_count <= '0;
        end else begin
            state     <= state_next;
            wr_ptr    <= wr_ptr_next;
            hop_cnt   <= hop_cnt_next;
            fft_load  <= (state_next == LOAD);
            fft_start <= (state_next == RUN);
            add_rd    <= (state == LOAD) ? add_rd + N'(1) : '0;
            if (state == PREFETCH) begin
                base <= wr_ptr_next;
            end
            if (state == FILL && state_next == PREFETCH) begin
                primed <= 1'b1;
            end
            if (state == RUN && fft_done) begin
                frame_count <= frame_count + 16'd1;
            end
            if (overrun_hit && overrun_count != 8'hFF) begin
                overrun_count <= overrun_count + 8'd1;
            end
        end
    end

    sample_ram #(
        .BIT_WIDTH(BIT_WIDTH),
        .N        (N),
        .DEPTH    (FFT_SIZE)
    ) u_sample_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (sample_valid),
        .wr_addr(wr_ptr),
        .wr_data(sample_in),
        .re     (ram_re),
        .rd_addr(ram_rd_addr),
        .rd_data(din)
    );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed scoreboard bench for fft_frame_sequencer (HOP=128 main instance,
// HOP=512 instance for non-overlapping frames).
module tb_fft_frame_sequencer;

    localparam int SIZE = 512;

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic        fft_done;
    logic        fft_load;
    logic [8:0]  add_rd;
    logic [15:0] din;
    logic        fft_start;
    logic        primed;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;

    logic        v_valid;
    logic [15:0] v_sample;
    logic        v_done;
    logic        v_load;
    logic [8:0]  v_addr;
    logic [15:0] v_din;
    logic        v_start;
    logic        v_primed;
    logic [15:0] v_frames;
    logic [7:0]  v_overruns;

    exp_t exp_q[$];
    exp_t hop_q[$];
    int   check_count = 0;
    int   pass_count  = 0;
    int   fail_count  = 0;
    int   idx         = 0;
    int   run_len     = 0;
    bit   allow_trunc = 1'b0;

    fft_frame_sequencer #(
        .BIT_WIDTH(16), .N(9), .FFT_SIZE(SIZE), .HOP(128)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .fft_done     (fft_done),
        .fft_load     (fft_load),
        .add_rd       (add_rd),
        .din          (din),
        .fft_start    (fft_start),
        .primed       (primed),
        .frame_count  (frame_count),
        .overrun_count(overrun_count)
    );

    fft_frame_sequencer #(
        .BIT_WIDTH(16), .N(9), .FFT_SIZE(SIZE), .HOP(512)
    ) u_dut_hop (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (v_valid),
        .sample_in    (v_sample),
        .fft_done     (v_done),
        .fft_load     (v_load),
        .add_rd       (v_addr),
        .din          (v_din),
        .fft_start    (v_start),
        .primed       (v_primed),
        .frame_count  (v_frames),
        .overrun_count(v_overruns)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic push_frame(input int first, input bit to_hop);
        for (int k = 0; k < SIZE; k++) begin
            exp_t e;
            e.addr = 9'(k);
            e.data = 16'(first + k);
            if (to_hop) hop_q.push_back(e);
            else        exp_q.push_back(e);
        end
    endtask

    task automatic apply_stimulus(input int count, input int gap);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_in    = 16'(idx);
            idx++;
            for (int g = 1; g < gap; g++) begin
                @(negedge clk);
                sample_valid = 1'b0;
            end
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
        check_output("start_drop", 32'(fft_start), 32'd0);
    endtask

    task automatic wait_start(input int budget, input string tag);
        int n = 0;
        while (fft_start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 32'(fft_start), 32'd1);
    endtask

    task automatic wait_hop_start(input int budget, input string tag);
        int n = 0;
        while (v_start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 32'(v_start), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_load"},    32'(fft_load), 32'd0);
        check_output({tag, "_start"},   32'(fft_start), 32'd0);
        check_output({tag, "_primed"},  32'(primed), 32'd0);
        check_output({tag, "_addr"},    32'(add_rd), 32'd0);
        check_output({tag, "_din"},     32'(din), 32'd0);
        check_output({tag, "_frames"},  32'(frame_count), 32'd0);
        check_output({tag, "_overrun"}, 32'(overrun_count), 32'd0);
    endtask

    // Every load beat of the main instance must match the front of the scoreboard.
    always @(negedge clk) begin
        exp_t cur;
        if (fft_load) begin
            run_len++;
            check_output("load_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check_output("load_addr", 32'(add_rd), 32'(cur.addr));
                check_output("load_din", 32'(din), 32'(cur.data));
            end
        end else if (run_len != 0) begin
            if (!allow_trunc) check_output("load_length", 32'(run_len), 32'(SIZE));
            run_len = 0;
        end
    end

    always @(negedge clk) begin
        exp_t cur;
        if (v_load) begin
            check_output("hop512_expected", 32'(hop_q.size() != 0), 32'd1);
            if (hop_q.size() != 0) begin
                cur = hop_q.pop_front();
                check_output("hop512_addr", 32'(v_addr), 32'(cur.addr));
                check_output("hop512_din", 32'(v_din), 32'(cur.data));
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        reset        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        fft_done     = 1'b0;
        v_valid      = 1'b0;
        v_sample     = '0;
        v_done       = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;

        // Fill at one sample every 4 cycles; load begins two cycles after the last.
        apply_stimulus(511, 4);
        push_frame(0, 1'b0);
        apply_stimulus(1, 1);
        check_output("fill_primed", 32'(primed), 32'd1);
        check_output("prefetch_no_load", 32'(fft_load), 32'd0);
        @(negedge clk);
        check_output("load_latency", 32'(fft_load), 32'd1);
        wait_start(600, "frame0_start");
        check_output("frame0_drained", 32'(exp_q.size()), 32'd0);
        check_output("frame0_count", 32'(frame_count), 32'd0);

        // One hop while the FFT is busy: no reload until done.
        apply_stimulus(128, 2);
        check_output("hop_start_held", 32'(fft_start), 32'd1);
        check_output("hop_no_frame", 32'(frame_count), 32'd0);
        check_output("hop_no_overrun", 32'(overrun_count), 32'd0);
        push_frame(128, 1'b0);
        pulse_done();
        check_output("hop_frame_count", 32'(frame_count), 32'd1);
        wait_start(600, "frame1_start");
        check_output("frame1_drained", 32'(exp_q.size()), 32'd0);

        // Two hops while busy: one overrun, next frame is the newest window.
        apply_stimulus(256, 2);
        check_output("overrun_count", 32'(overrun_count), 32'd1);
        push_frame(384, 1'b0);
        pulse_done();
        check_output("overrun_frame_count", 32'(frame_count), 32'd2);
        wait_start(600, "frame2_start");
        check_output("frame2_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back samples straight through PREFETCH and LOAD.
        apply_stimulus(127, 2);
        pulse_done();
        check_output("b2b_frame_count", 32'(frame_count), 32'd3);
        repeat (3) @(negedge clk);
        check_output("idle_below_hop", 32'(fft_load), 32'd0);
        push_frame(513, 1'b0);
        apply_stimulus(202, 1);
        wait_start(600, "b2b_start");
        check_output("b2b_overrun", 32'(overrun_count), 32'd1);
        check_output("b2b_drained", 32'(exp_q.size()), 32'd0);
        push_frame(713, 1'b0);
        pulse_done();
        check_output("carry_frame_count", 32'(frame_count), 32'd4);
        wait_start(600, "carry_start");
        check_output("carry_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a load, then a full refill.
        apply_stimulus(128, 2);
        push_frame(841, 1'b0);
        allow_trunc = 1'b1;
        pulse_done();
        check_output("pre_reset_frames", 32'(frame_count), 32'd5);
        n = 0;
        while (fft_load !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("reset_load_seen", 32'(fft_load), 32'd1);
        repeat (100) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midload_rst");
        exp_q.delete();
        reset = 1'b1;
        apply_stimulus(511, 1);
        check_output("refill_not_primed", 32'(primed), 32'd0);
        check_output("refill_no_load", 32'(fft_load), 32'd0);
        push_frame(1353, 1'b0);
        apply_stimulus(1, 1);
        check_output("refill_primed", 32'(primed), 32'd1);
        @(negedge clk);
        check_output("refill_load", 32'(fft_load), 32'd1);
        wait_start(600, "refill_start");
        check_output("refill_drained", 32'(exp_q.size()), 32'd0);
        check_output("refill_frames", 32'(frame_count), 32'd0);
        allow_trunc = 1'b0;

        // HOP = FFT_SIZE: consecutive non-overlapping frames.
        push_frame(0, 1'b1);
        for (int j = 0; j < SIZE; j++) begin
            @(negedge clk);
            v_valid  = 1'b1;
            v_sample = 16'(j);
        end
        @(negedge clk);
        v_valid = 1'b0;
        n = 0;
        while (v_load !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_output("hop512_load_seen", 32'(v_load), 32'd1);
        push_frame(SIZE, 1'b1);
        for (int j = SIZE; j < 2 * SIZE; j++) begin
            @(negedge clk);
            v_valid  = 1'b1;
            v_sample = 16'(j);
        end
        @(negedge clk);
        v_valid = 1'b0;
        wait_hop_start(600, "hop512_frame0_start");
        check_output("hop512_frames0", 32'(v_frames), 32'd0);
        @(negedge clk);
        v_done = 1'b1;
        @(negedge clk);
        v_done = 1'b0;
        check_output("hop512_frames1", 32'(v_frames), 32'd1);
        wait_hop_start(600, "hop512_frame1_start");
        check_output("hop512_drained", 32'(hop_q.size()), 32'd0);
        check_output("hop512_overrun", 32'(v_overruns), 32'd0);
        @(negedge clk);
        v_done = 1'b1;
        @(negedge clk);
        v_done = 1'b0;
        check_output("hop512_frames2", 32'(v_frames), 32'd2);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
